// File: rtl/maclaurin_pkg.sv
// Shared types, Q2.16 coefficient tables and coefficient lookup for the Maclaurin engine.
package maclaurin_pkg;

  typedef enum logic [1:0] {
    ModeLn   = 2'd0,
    ModeExp  = 2'd1,
    ModeSin  = 2'd2,
    ModeRsvd = 2'd3
  } mode_e;

  localparam int unsigned COEF_FRAC = 16;

  // c_k = round(v_k * 2^16), index k = power of x
  localparam logic signed [17:0] LnCoef [16] = '{
    18'sd0,      18'sd65536,  -18'sd32768, 18'sd21845,
    -18'sd16384, 18'sd13107,  -18'sd10923, 18'sd9362,
    -18'sd8192,  18'sd7282,   -18'sd6554,  18'sd5958,
    -18'sd5461,  18'sd5041,   -18'sd4681,  18'sd4369
  };

  localparam logic signed [17:0] ExpCoef [16] = '{
    18'sd65536, 18'sd65536, 18'sd32768, 18'sd10923,
    18'sd2731,  18'sd546,   18'sd91,    18'sd13,
    18'sd2,     18'sd0,     18'sd0,     18'sd0,
    18'sd0,     18'sd0,     18'sd0,     18'sd0
  };

  localparam logic signed [17:0] SinCoef [16] = '{
    18'sd0, 18'sd65536, 18'sd0, -18'sd10923,
    18'sd0, 18'sd546,   18'sd0, -18'sd13,
    18'sd0, 18'sd0,     18'sd0, 18'sd0,
    18'sd0, 18'sd0,     18'sd0, 18'sd0
  };

  function automatic logic signed [17:0] coef(input mode_e mode, input logic [3:0] k);
    case (mode)
      ModeLn:  return LnCoef[k];
      ModeExp: return ExpCoef[k];
      ModeSin: return SinCoef[k];
      default: return 18'sd0;
    endcase
  endfunction

endpackage

// File: rtl/maclaurin_mac_step.sv
// One Horner step: acc*x >>> (IN_WIDTH-1) plus aligned coefficient, with range checks.
module maclaurin_mac_step
  import maclaurin_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned FRAC_OUT     = 16,
  localparam int unsigned AccW        = OUTPUT_WIDTH + 2
) (
  input  logic signed [AccW-1:0]     acc_i,
  input  logic signed [IN_WIDTH-1:0] x_i,
  input  logic signed [17:0]         coef_i,
  output logic signed [AccW-1:0]     acc_o,
  output logic                       step_ovf_o,
  output logic                       out_ovf_o
);

  localparam int unsigned ProdW = AccW + IN_WIDTH;
  localparam int unsigned SumW  = ProdW + 1;

  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] shifted;
  logic signed [SumW-1:0]  coef_al;
  logic signed [SumW-1:0]  sum;
  logic [SumW-AccW:0]      sum_top;
  logic [AccW-OUTPUT_WIDTH:0] acc_top;

  always_comb begin
    prod    = $signed({{IN_WIDTH{acc_i[AccW-1]}}, acc_i}) *
              $signed({{AccW{x_i[IN_WIDTH-1]}}, x_i});
    shifted = prod >>> (IN_WIDTH - 1);
    coef_al = $signed({{(SumW-18){coef_i[17]}}, coef_i}) <<< (FRAC_OUT - COEF_FRAC);
    sum     = $signed({shifted[ProdW-1], shifted}) + coef_al;
    acc_o   = sum[AccW-1:0];
    // In range iff every bit above the target sign bit copies it
    sum_top    = sum[SumW-1:AccW-1];
    acc_top    = acc_o[AccW-1:OUTPUT_WIDTH-1];
    step_ovf_o = !((&sum_top) || !(|sum_top));
    out_ovf_o  = !((&acc_top) || !(|acc_top));
  end

endmodule

// File: rtl/maclaurin_engine.sv
// Iterative Horner evaluator for ln(1+x), e^x and sin x; one multiply-add per cycle.
// Define MACLAURIN_SAT_EN to saturate Y on overflow instead of wrapping.
module maclaurin_engine
  import maclaurin_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned FRAC_OUT     = 16,
  parameter int unsigned MAX_ORDER    = 7,
  localparam int unsigned NW          = $clog2(MAX_ORDER + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [NW-1:0]           N,
  input  logic [IN_WIDTH-1:0]     X,
  input  logic                    x_valid,
  output logic [OUTPUT_WIDTH-1:0] Y,
  output logic                    valid,
  output logic                    ready,
  output logic                    overflow,
  output logic                    error
);

  localparam int unsigned AccW = OUTPUT_WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StLoad, StCalc} state_e;

  state_e                     state_q;
  mode_e                      mode_q;
  logic [NW-1:0]              n_q;
  logic [NW-1:0]              k_q;
  logic signed [IN_WIDTH-1:0] x_q;
  logic signed [AccW-1:0]     acc_q;
  logic                       ovf_q;
  logic [OUTPUT_WIDTH-1:0]    y_q;
  logic                       valid_q;
  logic                       ready_q;
  logic                       overflow_q;
  logic                       error_q;

  logic [2**NW-1:0]           n_ok;
  logic                       legal;
  logic signed [AccW-1:0]     step_acc_in;
  logic [NW-1:0]              k_sel;
  logic signed [17:0]         coef_k;
  logic signed [AccW-1:0]     acc_step;
  logic                       step_ovf;
  logic                       out_ovf;
  logic                       ovf_any;
  logic [OUTPUT_WIDTH-1:0]    y_out;

  always_comb begin
    for (int i = 0; i < 2**NW; i++) begin
      n_ok[i] = (i >= 1) && (i <= int'(MAX_ORDER));
    end
    legal = (mode != 2'd3) && n_ok[N];
  end

  // Outside CALC the step sees acc=0, so its result is the aligned c_N used as the seed
  always_comb begin
    step_acc_in = (state_q == StCalc) ? acc_q : '0;
    k_sel       = (state_q == StCalc) ? k_q : n_q;
    coef_k      = coef(mode_q, 4'(k_sel));
  end

  maclaurin_mac_step #(
    .IN_WIDTH     (IN_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .FRAC_OUT     (FRAC_OUT)
  ) u_mac_step (
    .acc_i      (step_acc_in),
    .x_i        (x_q),
    .coef_i     (coef_k),
    .acc_o      (acc_step),
    .step_ovf_o (step_ovf),
    .out_ovf_o  (out_ovf)
  );

  always_comb begin
    ovf_any = ovf_q | step_ovf | out_ovf;
`ifdef MACLAURIN_SAT_EN
    if (ovf_any) begin
      y_out = acc_step[AccW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end else begin
      y_out = acc_step[OUTPUT_WIDTH-1:0];
    end
`else
    y_out = acc_step[OUTPUT_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= ModeLn;
      n_q        <= '0;
      k_q        <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (legal) begin
              mode_q  <= mode_e'(mode);
              n_q     <= N;
              error_q <= 1'b0;
              ready_q <= 1'b1;
              state_q <= StLoad;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          // start wins over a coincident sample, which is then not consumed
          if (start) begin
            if (legal) begin
              mode_q  <= mode_e'(mode);
              n_q     <= N;
              error_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
              ready_q <= 1'b0;
              state_q <= StIdle;
            end
          end else if (x_valid) begin
            x_q     <= X;
            acc_q   <= acc_step;
            k_q     <= n_q - 1'b1;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          k_q   <= k_q - 1'b1;
          ovf_q <= ovf_q | step_ovf;
          if (k_q == '0) begin
            y_q        <= y_out;
            overflow_q <= ovf_any;
            valid_q    <= 1'b1;
            ready_q    <= 1'b1;
            state_q    <= StLoad;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Y        = y_q;
  assign valid    = valid_q;
  assign ready    = ready_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule

// File: tb/tb_maclaurin_engine.sv
// Randomized self-checking bench for maclaurin_engine against a real-arithmetic series model.
module tb_maclaurin_engine;

  localparam int InW     = 8;
  localparam int OutW    = 32;
  localparam int Out18   = 18;
  localparam int FracOut = 16;
  localparam int MaxOrd  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [2:0]  n_in;
  logic [7:0]  x_in;
  logic        x_valid;

  logic [31:0] y;
  logic        valid, ready, overflow, error;
  logic [17:0] y18;
  logic        valid18, ready18, overflow18, error18;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_accept = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  maclaurin_engine #(
    .IN_WIDTH(InW), .OUTPUT_WIDTH(OutW), .FRAC_OUT(FracOut), .MAX_ORDER(MaxOrd)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .N(n_in), .X(x_in),
    .x_valid(x_valid), .Y(y), .valid(valid), .ready(ready), .overflow(overflow),
    .error(error)
  );

  maclaurin_engine #(
    .IN_WIDTH(InW), .OUTPUT_WIDTH(Out18), .FRAC_OUT(FracOut), .MAX_ORDER(MaxOrd)
  ) dut18 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .N(n_in), .X(x_in),
    .x_valid(x_valid), .Y(y18), .valid(valid18), .ready(ready18), .overflow(overflow18),
    .error(error18)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coefficient straight from the series definition, rounded to nearest in Q2.16
  function automatic longint coef_m(input int md, input int k);
    real v, f, r;
    longint c;
    f = 1.0;
    for (int i = 2; i <= k; i++) f = f * i;
    case (md)
      0:       v = (k == 0) ? 0.0 : (((k % 2) == 1) ? 1.0 : -1.0) / k;
      1:       v = 1.0 / f;
      default: v = ((k % 2) == 0) ? 0.0 : (((((k - 1) / 2) % 2) == 1) ? -1.0 : 1.0) / f;
    endcase
    r = v * 65536.0;
    c = (r >= 0.0) ? longint'($rtoi(r + 0.5)) : -longint'($rtoi(-r + 0.5));
    return c <<< (FracOut - 16);
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic void model(input int md, input int n, input int x, input int ow,
                                output longint yexp, output bit ovf);
    longint acc, lim;
    int aw;
    aw  = ow + 2;
    ovf = 1'b0;
    acc = coef_m(md, n);
    for (int k = n - 1; k >= 0; k--) begin
      acc = ((acc * x) >>> (InW - 1)) + coef_m(md, k);
      lim = longint'(1) << (aw - 1);
      if (acc < -lim || acc > lim - 1) begin
        ovf = 1'b1;
        acc = wrap(acc, aw);
      end
    end
    lim = longint'(1) << (ow - 1);
    if (acc < -lim || acc > lim - 1) ovf = 1'b1;
`ifdef MACLAURIN_SAT_EN
    if (ovf) yexp = (acc < 0) ? lim : lim - 1;
    else     yexp = acc & ((longint'(1) << ow) - 1);
`else
    yexp = acc & ((longint'(1) << ow) - 1);
`endif
  endfunction

  task automatic do_start(input int md, input int n);
    bit legal;
    legal = (md != 3) && (n >= 1) && (n <= MaxOrd);
    start = 1'b1;
    mode  = 2'(md);
    n_in  = 3'(n);
    tick();
    start = 1'b0;
    check("start.ready", longint'(ready), longint'(legal));
    check("start.error", longint'(error), longint'(!legal));
  endtask

  task automatic run_sample(input int md, input int n, input logic [7:0] xb);
    longint ey, ey18;
    bit     eo, eo18;
    int     lat;
    model(md, n, int'($signed(xb)), OutW, ey, eo);
    model(md, n, int'($signed(xb)), Out18, ey18, eo18);
    x_in    = xb;
    x_valid = 1'b1;
    tick();
    last_accept = cyc;
    x_valid = 1'b0;
    check("accept.ready", longint'(ready), 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!valid && lat < 40);
    check("latency", lat, n);
    check("y", longint'(y), ey);
    check("overflow", longint'(overflow), longint'(eo));
    check("ready@valid", longint'(ready), 1);
    check("valid18", longint'(valid18), 1);
    check("y18", longint'(y18), ey18);
    check("overflow18", longint'(overflow18), longint'(eo18));
  endtask

  initial begin
    int prev, nv, md, n, ns;
    rst = 1'b1; start = 1'b0; mode = '0; n_in = '0; x_in = '0; x_valid = 1'b0;
    repeat (3) tick();
    check("rst.y", longint'(y), 0);
    check("rst.valid", longint'(valid), 0);
    check("rst.ready", longint'(ready), 0);
    check("rst.overflow", longint'(overflow), 0);
    check("rst.error", longint'(error), 0);
    rst = 1'b0;
    tick();

    do_start(0, 1);
    run_sample(0, 1, 8'h40);
    check("ln.y_const", longint'(y), 'h8000);

    do_start(1, 2);
    run_sample(1, 2, 8'h40);
    check("exp.y_const", longint'(y), 'h1A000);
    tick();
    check("valid.pulse", longint'(valid), 0);

    do_start(2, 3);
    run_sample(2, 3, 8'h40);
    check("sin.y_const", longint'(y), 'h7AAA);
    prev = last_accept;
    run_sample(2, 3, 8'hC0);
    check("sin.accept_gap", last_accept - prev, 4);

    do_start(1, 0);
    do_start(3, 3);
    do_start(1, 4);

    do_start(1, 7);
    run_sample(1, 7, 8'h7F);
    check("sat.ovf18", longint'(overflow18), 1);
`ifdef MACLAURIN_SAT_EN
    check("sat.y18_const", longint'(y18), 'h1FFFF);
`endif

    do_start(1, 5);
    x_in = 8'h40; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.y", longint'(y), 0);
    check("midrst.valid", longint'(valid), 0);
    check("midrst.ready", longint'(ready), 0);
    check("midrst.overflow", longint'(overflow), 0);
    check("midrst.error", longint'(error), 0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid || ready) nv++;
    end
    check("midrst.quiet", nv, 0);
    do_start(1, 5);
    run_sample(1, 5, 8'h40);

    for (int it = 0; it < 24; it++) begin
      md = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, MaxOrd));
      do_start(md, n);
      if ($urandom_range(0, 4) == 0) begin
        do_start(3, n);
        do_start(md, n);
      end
      ns = int'($urandom_range(1, 3));
      for (int s = 0; s < ns; s++) run_sample(md, n, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
